// File: rtl/dmem_io_bridge.sv
// Purpose: splits processor data-memory accesses between dmem and a 4-word I/O window (LED, TIMER, TX FIFO, STATUS).
// Latency: dmem controls are combinational pass-through; every read returns on cpu_q one cycle after the address.
// Backpressure: TX FIFO drains on tx_valid && tx_ready; a push into a full FIFO with no pop is dropped and sets sticky overflow.
module dmem_io_bridge #(
   parameter int          FIFO_DEPTH = 4,        // power of two, 2..16
   parameter logic [11:0] IO_BASE    = 12'hFF0   // low 4 bits zero
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] cpu_address,
   input  logic [31:0] cpu_data,
   input  logic        cpu_wren,
   output logic [31:0] cpu_q,
   output logic [11:0] dmem_address,
   output logic [31:0] dmem_data,
   output logic        dmem_wren,
   input  logic [31:0] dmem_q,
   output logic [15:0] led,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [1:0] OFF_LED    = 2'd0;
   localparam logic [1:0] OFF_TIMER  = 2'd1;
   localparam logic [1:0] OFF_TX     = 2'd2;
   localparam logic [1:0] OFF_STATUS = 2'd3;

   // architectural state
   logic [15:0]   r_led;
   logic [31:0]   r_timer;
   logic          r_io_hit;
   logic [31:0]   r_rd_val;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_cnt;
   logic          r_ovf;
   logic [7:0]    r_tx_data;
   logic [7:0]    r_mem [FIFO_DEPTH];

   // decode and FIFO control
   logic          w_io_hit;
   logic [1:0]    w_off;
   logic          w_io_wr;
   logic          w_wr_led;
   logic          w_wr_timer;
   logic          w_push_req;
   logic          w_wr_status;
   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic          w_ovf_set;
   logic [PW-1:0] w_rd_ptr_nxt;
   logic [PW-1:0] w_wr_ptr_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [7:0]    w_head_nxt;
   logic [4:0]    w_cnt5;
   logic [31:0]   w_status;
   logic [31:0]   w_rd_val;

   // Only the top four words of the 16-word block at IO_BASE are I/O;
   // everything else, including IO_BASE+0..11, belongs to dmem.
   assign w_io_hit    = (cpu_address[11:4] == IO_BASE[11:4]) && (cpu_address[3:2] == 2'b11);
   assign w_off       = cpu_address[1:0];
   assign w_io_wr     = w_io_hit && cpu_wren;
   assign w_wr_led    = w_io_wr && (w_off == OFF_LED);
   assign w_wr_timer  = w_io_wr && (w_off == OFF_TIMER);
   assign w_push_req  = w_io_wr && (w_off == OFF_TX);
   assign w_wr_status = w_io_wr && (w_off == OFF_STATUS);

   // dmem sees the processor bus directly; only I/O writes are masked.
   assign dmem_address = cpu_address;
   assign dmem_data    = cpu_data;
   assign dmem_wren    = cpu_wren && !w_io_hit;

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == DEPTH_C);
   assign w_pop   = !w_empty && tx_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push    = w_push_req && (!w_full || w_pop);
   assign w_ovf_set = w_push_req && w_full && !w_pop;

   assign w_rd_ptr_nxt = w_pop  ? (r_rd_ptr + PW'(1)) : r_rd_ptr;
   assign w_wr_ptr_nxt = w_push ? (r_wr_ptr + PW'(1)) : r_wr_ptr;

   // Occupancy after this edge; simultaneous push and pop cancel out.
   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_push, w_pop})
         2'b10:   w_cnt_nxt = r_cnt + CW'(1);
         2'b01:   w_cnt_nxt = r_cnt - CW'(1);
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   // Head byte after this edge: the slot being written this edge is not yet
   // in r_mem, so forward cpu_data when the new head is that slot.
   always_comb begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
      if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
         w_head_nxt = cpu_data[7:0];
      end
      if (w_cnt_nxt == '0) begin
         w_head_nxt = 8'h00;
      end
   end

   assign w_cnt5   = 5'(r_cnt);
   assign w_status = {24'h000000, r_ovf, w_cnt5, w_full, w_empty};

   // I/O read value as seen at this edge; registered below for 1-cycle latency.
   always_comb begin
      w_rd_val = 32'h0;
      case (w_off)
         OFF_LED:    w_rd_val = {16'h0000, r_led};
         OFF_TIMER:  w_rd_val = r_timer;
         OFF_TX:     w_rd_val = 32'h0;
         OFF_STATUS: w_rd_val = w_status;
         default:    w_rd_val = 32'h0;
      endcase
   end

   // Read-select pipeline stage matching dmem's one-cycle read latency.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_io_hit <= 1'b0;
         r_rd_val <= 32'h0;
      end else begin
         r_io_hit <= w_io_hit;
         r_rd_val <= w_io_hit ? w_rd_val : 32'h0;
      end
   end

   assign cpu_q = r_io_hit ? r_rd_val : dmem_q;

   // LED register, loaded from the low half of the write data.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_led <= 16'h0000;
      end else if (w_wr_led) begin
         r_led <= cpu_data[15:0];
      end
   end

   assign led = r_led;

   // Free-running timer; a write clears it and takes precedence over the increment.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_timer <= 32'h0;
      end else if (w_wr_timer) begin
         r_timer <= 32'h0;
      end else begin
         r_timer <= r_timer + 32'd1;
      end
   end

   // FIFO storage has no reset; occupancy and pointers define what is valid.
   always_ff @(posedge clock) begin
      if (!reset && w_push) begin
         r_mem[r_wr_ptr] <= cpu_data[7:0];
      end
   end

   // FIFO pointers, occupancy, sticky overflow and the registered head byte.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_ptr  <= '0;
         r_wr_ptr  <= '0;
         r_cnt     <= '0;
         r_ovf     <= 1'b0;
         r_tx_data <= 8'h00;
      end else begin
         r_rd_ptr  <= w_rd_ptr_nxt;
         r_wr_ptr  <= w_wr_ptr_nxt;
         r_cnt     <= w_cnt_nxt;
         r_tx_data <= w_head_nxt;
         if (w_wr_status) begin
            r_ovf <= 1'b0;
         end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign tx_valid = !w_empty;
   assign tx_data  = r_tx_data;

endmodule
